apb2axi_rd_scheduler: RTL and testbench
=======================================

APB2AXI_RD_SCHEDULER -- requirements
Module: apb2axi_rd_scheduler

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- AXI_ID_W, 2, AXI ID width; slot count NSLOT = 2**AXI_ID_W.
- AXI_ADDR_W, 32, address width.
- MAX_OUT, 4, maximum outstanding reads, 1..NSLOT.
REQ-002 Ports SHALL be (name, direction, width, meaning); reset aresetn, asynchronous, active-low; clock aclk:
- aclk  in  1  clock
- aresetn  in  1  async active-low reset
- req_valid  in  1  read request present
- req_ready  out  1  request accepted this cycle
- req_tag  in  AXI_ID_W  request tag, used as ARID
- req_addr  in  AXI_ADDR_W  start address
- req_len  in  4  beats-1
- req_size  in  3  beat size
- arid/araddr/arlen/arsize  out  AXI_ID_W/AXI_ADDR_W/4/3  AR payload
- arburst  out  2  fixed 2'b01 INCR
- arvalid  out  1  AR valid
- arready  in  1  AR ready
- rid  in  AXI_ID_W  R ID
- rresp  in  2  R response
- rlast  in  1  last beat
- rvalid  in  1  R valid
- rready  out  1  R ready
- cpl_valid  out  1  one-cycle completion pulse
- cpl_tag  out  AXI_ID_W  completed tag
- cpl_resp  out  2  worst response of burst
- cpl_beats  out  5  beats received
- outstanding  out  3  reads in flight
- proto_err  out  1  sticky protocol error flag

Function
REQ-003 The AR side SHALL be a 2-state FSM: AR_IDLE (arvalid=0), AR_PEND (arvalid=1).
REQ-004 In AR_IDLE, req_ready SHALL be 1 combinationally iff req_valid=1, outstanding<MAX_OUT, slot[req_tag] is not busy, and no completion frees slot[req_tag] in the same cycle.
REQ-005 On req_valid&&req_ready the request SHALL be registered into the AR payload, and the FSM SHALL go to AR_PEND next cycle.
REQ-006 In AR_PEND the AR payload SHALL be held stable, req_ready SHALL be 0, and on arready=1 the FSM SHALL return to AR_IDLE.
REQ-007 At the AR handshake, slot[arid] SHALL become busy with expected=arlen+1, count=0, resp=2'b00, and outstanding SHALL increment.
REQ-008 A slot SHALL be marked busy at the AR handshake, not at request accept; outstanding SHALL include the AR_PEND entry when computing REQ-004.
REQ-009 rready SHALL be 1 whenever aresetn=1; every rvalid beat SHALL be consumed the same cycle.
REQ-010 On a beat whose rid hits a busy slot, count SHALL increment (5-bit, saturate at 16), and resp SHALL update to the maximum of the stored value and rresp.
REQ-011 On an rlast beat to a busy slot, the next cycle SHALL present cpl_valid=1 with cpl_tag=rid, cpl_beats=final count, and cpl_resp as in REQ-010; the slot SHALL be freed, and outstanding SHALL decrement.
REQ-012 If final count differs from expected (early or missing rlast), cpl_resp SHALL be forced to 2'b10 and proto_err SHALL set.
REQ-013 A beat whose rid hits a non-busy slot SHALL be dropped with no slot change, and proto_err SHALL set.
REQ-014 An AR handshake and a completion in the same cycle SHALL leave outstanding unchanged; this includes the same tag only if freed first (REQ-004 prevents the conflict).
REQ-015 proto_err SHALL remain set until reset.
REQ-016 Completions SHALL be issued in R-arrival order, with no back-pressure and at most one per cycle.

Reset
REQ-017 While aresetn=0 the block SHALL hold: arvalid=0, req_ready=0, rready=0, cpl_valid=0, all payload outputs 0 except arburst=2'b01, outstanding=0, proto_err=0, all slots free, FSM=AR_IDLE.
REQ-018 A reset asserted mid-burst SHALL discard all slots immediately, and no completion SHALL be produced for the interrupted burst.

Verification
REQ-019 Single read: tag=1, addr=0x100, len=3, arready held 1, four OKAY beats -> one AR cycle with arid=1; cpl_valid one cycle after rlast with cpl_beats=4, cpl_resp=0; outstanding returns 0.
REQ-020 Four outstanding: tags 0-3 back-to-back with arready=1 -> outstanding=4; a fifth request sees req_ready=0; interleaved rlast for tag 2 -> cpl_tag=2, then the fifth request is accepted.
REQ-021 Back-pressure: arready=0 for 5 cycles -> arvalid stays 1, payload is stable, req_ready=0; AR fires on cycle 6.
REQ-022 Error merge: len=1, beats with rresp 2'b00 then 2'b11 -> cpl_resp=2'b11.
REQ-023 Protocol faults: rlast on beat 2 of len=3 -> cpl_resp=2'b10, cpl_beats=2, proto_err=1; a beat with rid for a free slot -> dropped, proto_err=1.
REQ-024 Reset at beat 2 of 4 -> all outputs at reset values; no cpl_valid; after release a new tag=1 read completes normally.

Source files
------------

// File: rtl/apb2axi_rd_scheduler.sv
// ---------------------------------------------------------------------------
// apb2axi_rd_scheduler
//
// Turns tagged read requests into AXI AR transactions and tracks each tag's
// R burst until it completes. One AR can be pending at a time. Each in-flight
// read has its own slot, indexed by its tag, which is also used as ARID. When
// rlast arrives, the block emits a one-cycle completion pulse that carries the
// beat count and the worst response seen in the burst.
//
// Ports
//   aclk, aresetn          clock, asynchronous active-low reset
//   req_*                  request in (valid/ready, tag, addr, len, size)
//   ar*                    AXI read-address channel out (arburst fixed INCR)
//   rid/rresp/rlast/rvalid AXI read-data channel in; rready is always high
//                          out of reset
//   cpl_*                  completion pulse: tag, merged response, beats
//   outstanding            number of reads in flight (AR accepted, no rlast)
//   proto_err              sticky protocol-error flag, cleared only by reset
// ---------------------------------------------------------------------------
module apb2axi_rd_scheduler #(
    parameter int AXI_ID_W   = 2,
    parameter int AXI_ADDR_W = 32,
    parameter int MAX_OUT    = 4
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [AXI_ID_W-1:0]   req_tag,
    input  logic [AXI_ADDR_W-1:0] req_addr,
    input  logic [3:0]            req_len,
    input  logic [2:0]            req_size,
    output logic [AXI_ID_W-1:0]   arid,
    output logic [AXI_ADDR_W-1:0] araddr,
    output logic [3:0]            arlen,
    output logic [2:0]            arsize,
    output logic [1:0]            arburst,
    output logic                  arvalid,
    input  logic                  arready,
    input  logic [AXI_ID_W-1:0]   rid,
    input  logic [1:0]            rresp,
    input  logic                  rlast,
    input  logic                  rvalid,
    output logic                  rready,
    output logic                  cpl_valid,
    output logic [AXI_ID_W-1:0]   cpl_tag,
    output logic [1:0]            cpl_resp,
    output logic [4:0]            cpl_beats,
    output logic [2:0]            outstanding,
    output logic                  proto_err
);

    localparam int         NSLOT     = 2**AXI_ID_W;
    localparam logic [2:0] MAX_OUT_C = 3'(MAX_OUT);
    localparam logic [4:0] CNT_SAT   = 5'd16;

    typedef enum logic {AR_IDLE = 1'b0, AR_PEND = 1'b1} ar_state_e;

    ar_state_e ar_state_q, ar_state_d;

    logic [AXI_ID_W-1:0]   arid_q, arid_d;
    logic [AXI_ADDR_W-1:0] araddr_q, araddr_d;
    logic [3:0]            arlen_q, arlen_d;
    logic [2:0]            arsize_q, arsize_d;

    // Per-tag slot state.
    logic [NSLOT-1:0] busy_q, busy_d;
    logic [4:0]       exp_q  [NSLOT];
    logic [4:0]       exp_d  [NSLOT];
    logic [4:0]       cnt_q  [NSLOT];
    logic [4:0]       cnt_d  [NSLOT];
    logic [1:0]       resp_q [NSLOT];
    logic [1:0]       resp_d [NSLOT];

    logic [2:0]          out_q, out_d;
    logic                perr_q, perr_d;
    logic                cpl_valid_q, cpl_valid_d;
    logic [AXI_ID_W-1:0] cpl_tag_q, cpl_tag_d;
    logic [1:0]          cpl_resp_q, cpl_resp_d;
    logic [4:0]          cpl_beats_q, cpl_beats_d;

    logic       req_hs, ar_hs, beat_hit, cpl_fire;
    logic [4:0] beat_cnt;
    logic [1:0] beat_resp;

    assign req_hs    = req_valid && req_ready;
    assign ar_hs     = arvalid && arready;
    assign beat_hit  = rvalid && busy_q[rid];
    assign cpl_fire  = beat_hit && rlast;
    assign beat_cnt  = (cnt_q[rid] == CNT_SAT) ? CNT_SAT : cnt_q[rid] + 5'd1;
    // AXI responses are ordered by severity, so the worst response is the max.
    assign beat_resp = (rresp > resp_q[rid]) ? rresp : resp_q[rid];

    // ---------------- AR FSM: state register ----------------
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            ar_state_q <= AR_IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignment, so every flop samples pre-edge values.
            ar_state_q <= ar_state_d;
        end
    end

    // ---------------- AR FSM: next state ----------------
    always_comb begin
        ar_state_d = ar_state_q;
        if (ar_state_q == AR_IDLE) begin
            if (req_hs) ar_state_d = AR_PEND;
        end else begin
            if (arready) ar_state_d = AR_IDLE;
        end
    end

    // ---------------- AR FSM: outputs ----------------
    // The outstanding count only matters in AR_IDLE, where no AR is pending.
    // A tag that completes this cycle stays busy until the clock edge, so it
    // cannot be reissued in the same cycle.
    always_comb begin
        arvalid   = 1'b0;
        req_ready = 1'b0;
        if (ar_state_q == AR_PEND) begin
            arvalid = 1'b1;
        end else begin
            req_ready = aresetn && req_valid && (out_q < MAX_OUT_C) &&
                        !busy_q[req_tag] && !(cpl_fire && (rid == req_tag));
        end
    end

    // ---------------- Datapath next state ----------------
    always_comb begin
        // NOTE: every *_d gets its hold value first so that no path leaves it unassigned (no latches).
        arid_d      = arid_q;
        araddr_d    = araddr_q;
        arlen_d     = arlen_q;
        arsize_d    = arsize_q;
        busy_d      = busy_q;
        exp_d       = exp_q;
        cnt_d       = cnt_q;
        resp_d      = resp_q;
        out_d       = out_q;
        perr_d      = perr_q;
        cpl_valid_d = 1'b0;
        cpl_tag_d   = cpl_tag_q;
        cpl_resp_d  = cpl_resp_q;
        cpl_beats_d = cpl_beats_q;

        if (req_hs) begin
            arid_d   = req_tag;
            araddr_d = req_addr;
            arlen_d  = req_len;
            arsize_d = req_size;
        end

        if (beat_hit) begin
            if (rlast) begin
                busy_d[rid] = 1'b0;
                cpl_valid_d = 1'b1;
                cpl_tag_d   = rid;
                cpl_beats_d = beat_cnt;
                // A short or overlong burst is reported as SLVERR.
                if (beat_cnt != exp_q[rid]) begin
                    cpl_resp_d = 2'b10;
                    perr_d     = 1'b1;
                end else begin
                    cpl_resp_d = beat_resp;
                end
            end else begin
                cnt_d[rid]  = beat_cnt;
                resp_d[rid] = beat_resp;
            end
        end else if (rvalid) begin
            // Beat for a tag with no read in flight: drop it and flag the error.
            perr_d = 1'b1;
        end

        // The slot becomes busy only when the AR is accepted on the bus.
        if (ar_hs) begin
            busy_d[arid_q] = 1'b1;
            exp_d[arid_q]  = {1'b0, arlen_q} + 5'd1;
            cnt_d[arid_q]  = '0;
            resp_d[arid_q] = '0;
        end

        case ({ar_hs, cpl_fire})
            2'b10:   out_d = out_q + 3'd1;
            2'b01:   out_d = out_q - 3'd1;
            default: out_d = out_q;
        endcase
    end

    // ---------------- Datapath registers ----------------
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            arid_q      <= '0;
            araddr_q    <= '0;
            arlen_q     <= '0;
            arsize_q    <= '0;
            busy_q      <= '0;
            // NOTE: the slot array is flop-based and small, so it is cleared on reset; a mid-burst reset discards every read in flight.
            for (int i = 0; i < NSLOT; i++) begin
                exp_q[i]  <= '0;
                cnt_q[i]  <= '0;
                resp_q[i] <= '0;
            end
            out_q       <= '0;
            perr_q      <= 1'b0;
            cpl_valid_q <= 1'b0;
            cpl_tag_q   <= '0;
            cpl_resp_q  <= '0;
            cpl_beats_q <= '0;
        end else begin
            arid_q      <= arid_d;
            araddr_q    <= araddr_d;
            arlen_q     <= arlen_d;
            arsize_q    <= arsize_d;
            busy_q      <= busy_d;
            exp_q       <= exp_d;
            cnt_q       <= cnt_d;
            resp_q      <= resp_d;
            out_q       <= out_d;
            perr_q      <= perr_d;
            cpl_valid_q <= cpl_valid_d;
            cpl_tag_q   <= cpl_tag_d;
            cpl_resp_q  <= cpl_resp_d;
            cpl_beats_q <= cpl_beats_d;
        end
    end

    assign arid        = arid_q;
    assign araddr      = araddr_q;
    assign arlen       = arlen_q;
    assign arsize      = arsize_q;
    assign arburst     = 2'b01;
    assign rready      = aresetn;
    assign cpl_valid   = cpl_valid_q;
    assign cpl_tag     = cpl_tag_q;
    assign cpl_resp    = cpl_resp_q;
    assign cpl_beats   = cpl_beats_q;
    assign outstanding = out_q;
    assign proto_err   = perr_q;

endmodule

// File: tb/tb_apb2axi_rd_scheduler.sv
// ---------------------------------------------------------------------------
// tb_apb2axi_rd_scheduler
//
// Directed scenarios followed by a randomized phase. Expected values come from
// a transaction-level model of in-flight reads, kept per tag: beats expected,
// beats seen, and worst response. Inputs are driven 1 time unit after the
// rising edge. Outputs are sampled before the next edge.
// ---------------------------------------------------------------------------
module tb_apb2axi_rd_scheduler;

    localparam int AXI_ID_W   = 2;
    localparam int AXI_ADDR_W = 32;
    localparam int MAX_OUT    = 4;
    localparam int NSLOT      = 4;

    logic                  aclk;
    logic                  aresetn;
    logic                  req_valid;
    logic                  req_ready;
    logic [AXI_ID_W-1:0]   req_tag;
    logic [AXI_ADDR_W-1:0] req_addr;
    logic [3:0]            req_len;
    logic [2:0]            req_size;
    logic [AXI_ID_W-1:0]   arid;
    logic [AXI_ADDR_W-1:0] araddr;
    logic [3:0]            arlen;
    logic [2:0]            arsize;
    logic [1:0]            arburst;
    logic                  arvalid;
    logic                  arready;
    logic [AXI_ID_W-1:0]   rid;
    logic [1:0]            rresp;
    logic                  rlast;
    logic                  rvalid;
    logic                  rready;
    logic                  cpl_valid;
    logic [AXI_ID_W-1:0]   cpl_tag;
    logic [1:0]            cpl_resp;
    logic [4:0]            cpl_beats;
    logic [2:0]            outstanding;
    logic                  proto_err;

    apb2axi_rd_scheduler #(
        .AXI_ID_W  (AXI_ID_W),
        .AXI_ADDR_W(AXI_ADDR_W),
        .MAX_OUT   (MAX_OUT)
    ) dut (
        .aclk       (aclk),
        .aresetn    (aresetn),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_tag    (req_tag),
        .req_addr   (req_addr),
        .req_len    (req_len),
        .req_size   (req_size),
        .arid       (arid),
        .araddr     (araddr),
        .arlen      (arlen),
        .arsize     (arsize),
        .arburst    (arburst),
        .arvalid    (arvalid),
        .arready    (arready),
        .rid        (rid),
        .rresp      (rresp),
        .rlast      (rlast),
        .rvalid     (rvalid),
        .rready     (rready),
        .cpl_valid  (cpl_valid),
        .cpl_tag    (cpl_tag),
        .cpl_resp   (cpl_resp),
        .cpl_beats  (cpl_beats),
        .outstanding(outstanding),
        .proto_err  (proto_err)
    );

    initial begin
        aclk = 1'b0;
        forever #5 aclk = ~aclk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: one entry per tag.
    bit m_live  [NSLOT];
    int m_exp   [NSLOT];
    int m_got   [NSLOT];
    int m_worst [NSLOT];
    int m_out;
    bit m_perr;

    // Expected completion for the most recent cycle.
    bit exp_cpl;
    int exp_ctag, exp_cbeats, exp_cresp;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic model_clear();
        for (int i = 0; i < NSLOT; i++) begin
            m_live[i]  = 1'b0;
            m_exp[i]   = 0;
            m_got[i]   = 0;
            m_worst[i] = 0;
        end
        m_out   = 0;
        m_perr  = 1'b0;
        exp_cpl = 1'b0;
    endtask

    // Applies one R beat to the model and sets the expected completion.
    task automatic model_beat(input int tag, input int resp, input bit last);
        exp_cpl = 1'b0;
        if (m_live[tag]) begin
            m_got[tag] = (m_got[tag] < 16) ? m_got[tag] + 1 : 16;
            if (resp > m_worst[tag]) m_worst[tag] = resp;
            if (last) begin
                exp_cpl    = 1'b1;
                exp_ctag   = tag;
                exp_cbeats = m_got[tag];
                if (m_got[tag] != m_exp[tag]) begin
                    exp_cresp = 2;
                    m_perr    = 1'b1;
                end else begin
                    exp_cresp = m_worst[tag];
                end
                m_live[tag] = 1'b0;
                m_out--;
            end
        end else begin
            m_perr = 1'b1;
        end
    endtask

    task automatic check_cpl();
        check("cpl_valid", cpl_valid, exp_cpl);
        if (exp_cpl) begin
            check("cpl_tag", cpl_tag, exp_ctag);
            check("cpl_beats", cpl_beats, exp_cbeats);
            check("cpl_resp", cpl_resp, exp_cresp);
        end
        check("proto_err", proto_err, m_perr);
        check("outstanding", outstanding, m_out);
    endtask

    task automatic check_reset();
        check("rst_req_ready", req_ready, 0);
        check("rst_arvalid", arvalid, 0);
        check("rst_rready", rready, 0);
        check("rst_cpl_valid", cpl_valid, 0);
        check("rst_cpl_tag", cpl_tag, 0);
        check("rst_cpl_resp", cpl_resp, 0);
        check("rst_cpl_beats", cpl_beats, 0);
        check("rst_arid", arid, 0);
        check("rst_araddr", araddr, 0);
        check("rst_arlen", arlen, 0);
        check("rst_arsize", arsize, 0);
        check("rst_arburst", arburst, 2'b01);
        check("rst_outstanding", outstanding, 0);
        check("rst_proto_err", proto_err, 0);
    endtask

    task automatic do_reset();
        aresetn   = 1'b0;
        req_valid = 1'b1;
        req_tag   = '0;
        #2;
        check_reset();
        tick();
        #2;
        aresetn   = 1'b1;
        req_valid = 1'b0;
        model_clear();
        tick();
    endtask

    task automatic check_ar(input int tag, input logic [31:0] addr, input int len, input int size);
        check("arvalid", arvalid, 1);
        check("arid", arid, tag);
        check("araddr", araddr, addr);
        check("arlen", arlen, len);
        check("arsize", arsize, size);
        check("arburst", arburst, 2'b01);
    endtask

    // Presents a request. If the model says it should be accepted, waits
    // ar_delay cycles with arready low and then completes the AR. If beat_tag
    // is >= 0, an rlast beat for beat_tag arrives in the handshake cycle.
    task automatic send_req(input int tag, input logic [31:0] addr, input int len,
                            input int size, input int ar_delay, input int beat_tag);
        bit exp_rdy;
        exp_rdy   = !m_live[tag] && (m_out < MAX_OUT);
        req_valid = 1'b1;
        req_tag   = 2'(tag);
        req_addr  = addr;
        req_len   = 4'(len);
        req_size  = 3'(size);
        #1;
        check("req_ready", req_ready, exp_rdy);
        tick();
        if (!exp_rdy) begin
            req_valid = 1'b0;
            return;
        end
        // Unrelated request traffic while the AR is pending.
        req_tag  = 2'($urandom);
        req_addr = $urandom;
        req_len  = 4'($urandom);
        req_size = 3'($urandom);
        for (int d = 0; d < ar_delay; d++) begin
            arready = 1'b0;
            #1;
            check_ar(tag, addr, len, size);
            check("req_ready_pend", req_ready, 0);
            tick();
        end
        arready = 1'b1;
        if (beat_tag >= 0) begin
            rvalid = 1'b1;
            rid    = 2'(beat_tag);
            rresp  = 2'b00;
            rlast  = 1'b1;
        end
        #1;
        check_ar(tag, addr, len, size);
        tick();
        arready   = 1'b0;
        req_valid = 1'b0;
        rvalid    = 1'b0;
        rlast     = 1'b0;
        m_live[tag]  = 1'b1;
        m_exp[tag]   = len + 1;
        m_got[tag]   = 0;
        m_worst[tag] = 0;
        m_out++;
        exp_cpl = 1'b0;
        if (beat_tag >= 0) model_beat(beat_tag, 0, 1'b1);
        check("arvalid_done", arvalid, 0);
        check_cpl();
    endtask

    task automatic send_beat(input int tag, input int resp, input bit last);
        rvalid = 1'b1;
        rid    = 2'(tag);
        rresp  = 2'(resp);
        rlast  = last;
        #1;
        check("rready", rready, 1);
        tick();
        rvalid = 1'b0;
        rlast  = 1'b0;
        model_beat(tag, resp, last);
        check_cpl();
    endtask

    initial begin
        aresetn   = 1'b0;
        req_valid = 1'b0;
        req_tag   = '0;
        req_addr  = '0;
        req_len   = '0;
        req_size  = '0;
        arready   = 1'b0;
        rid       = '0;
        rresp     = '0;
        rlast     = 1'b0;
        rvalid    = 1'b0;
        model_clear();

        tick();
        do_reset();

        // Single read, four OKAY beats.
        send_req(1, 32'h100, 3, 2, 0, -1);
        for (int b = 0; b < 4; b++) send_beat(1, 0, b == 3);
        tick();
        check("cpl_pulse_width", cpl_valid, 0);

        // Error merge.
        send_req(0, 32'h200, 1, 2, 0, -1);
        send_beat(0, 0, 1'b0);
        send_beat(0, 3, 1'b1);

        // AR back-pressure for 5 cycles.
        send_req(2, 32'hABC0, 7, 3, 5, -1);
        for (int b = 0; b < 8; b++) send_beat(2, 0, b == 7);

        // Four outstanding reads, then a fifth request is refused.
        send_req(0, 32'h1000, 1, 2, 0, -1);
        send_req(1, 32'h2000, 1, 2, 0, -1);
        send_req(2, 32'h3000, 1, 2, 0, -1);
        send_req(3, 32'h4000, 1, 2, 0, -1);
        send_req(1, 32'h5000, 0, 2, 0, -1);
        send_beat(0, 0, 1'b0);
        send_beat(2, 0, 1'b0);
        send_beat(1, 0, 1'b0);
        // rlast for tag 2 while a new tag-2 request is presented.
        req_valid = 1'b1;
        req_tag   = 2'd2;
        rvalid    = 1'b1;
        rid       = 2'd2;
        rresp     = 2'b00;
        rlast     = 1'b1;
        #1;
        check("req_ready_same_free", req_ready, !m_live[2]);
        tick();
        req_valid = 1'b0;
        rvalid    = 1'b0;
        rlast     = 1'b0;
        model_beat(2, 0, 1'b1);
        check_cpl();
        // Fifth request accepted; its AR handshake coincides with tag 0 completing.
        send_req(2, 32'h6000, 0, 2, 0, 0);
        send_beat(1, 0, 1'b1);
        send_beat(3, 0, 1'b0);
        send_beat(3, 0, 1'b1);
        send_beat(2, 1, 1'b1);

        // Early rlast.
        send_req(3, 32'h300, 3, 2, 0, -1);
        send_beat(3, 0, 1'b0);
        send_beat(3, 0, 1'b1);

        // Reset during beat 3 of 4.
        send_req(1, 32'h400, 3, 2, 0, -1);
        send_beat(1, 0, 1'b0);
        send_beat(1, 0, 1'b0);
        rvalid    = 1'b1;
        rid       = 2'd1;
        rresp     = 2'b00;
        rlast     = 1'b0;
        req_valid = 1'b1;
        req_tag   = 2'd0;
        aresetn   = 1'b0;
        #1;
        check_reset();
        for (int i = 0; i < 2; i++) begin
            rlast = (i == 1);
            tick();
            check("cpl_in_reset", cpl_valid, 0);
        end
        rvalid    = 1'b0;
        rlast     = 1'b0;
        req_valid = 1'b0;
        #2;
        aresetn = 1'b1;
        model_clear();
        tick();
        check("cpl_after_reset", cpl_valid, 0);
        send_req(1, 32'h500, 3, 2, 0, -1);
        for (int b = 0; b < 4; b++) send_beat(1, 0, b == 3);

        // Stray beat to a free slot.
        send_beat(2, 1, 1'b1);

        // Randomized traffic.
        do_reset();
        for (int it = 0; it < 400; it++) begin
            int op;
            int t;
            op = $urandom_range(0, 9);
            t  = $urandom_range(0, NSLOT - 1);
            if (op < 4) begin
                send_req(t, $urandom, $urandom_range(0, 4), $urandom_range(0, 7),
                         $urandom_range(0, 2), -1);
            end else if (op < 9) begin
                if (m_live[t]) begin
                    bit last;
                    if (m_got[t] + 1 >= m_exp[t]) last = ($urandom_range(0, 9) != 0);
                    else                          last = ($urandom_range(0, 19) == 0);
                    send_beat(t, $urandom_range(0, 3), last);
                end else begin
                    tick();
                end
            end else begin
                if (!m_live[t]) send_beat(t, $urandom_range(0, 3), $urandom_range(0, 1) == 1);
                else tick();
            end
        end
        // Drain whatever is still in flight.
        for (int t = 0; t < NSLOT; t++) begin
            if (m_live[t]) send_beat(t, 0, 1'b1);
        end
        check("outstanding_drained", outstanding, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
